// File: rtl/lcd_feeder_pkg.sv
// Shared types and widths for the LCD status feeder and its pending-update queue.
package lcd_feeder_pkg;

    localparam int unsigned ESTADO_W  = 22;
    localparam int unsigned OPCODE_W  = 5;
    localparam int unsigned ENTRY_W   = ESTADO_W + OPCODE_W;
    localparam int unsigned PENDING_W = 5;
    localparam int unsigned TIMER_W   = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } feeder_state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [ESTADO_W-1:0] estado,
                                                      input logic [OPCODE_W-1:0] opcode);
        return {estado, opcode};
    endfunction

endpackage

// File: rtl/lcd_status_fifo.sv
// Small FIFO with wrapping pointers and a separate occupancy counter.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module lcd_status_fifo #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign empty_o   = (count_q == {CW{1'b0}});
    assign full_o    = (count_q == CW'(DEPTH));
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rdata_o   = mem_q[rptr_q];
    assign count_o   = count_q;

    // Next-state pointers and occupancy; pointer wrap relies on DEPTH being a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push_s) begin
            wptr_d = wptr_q + AW'(1'b1);
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + AW'(1'b1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, counter and storage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push_s) begin
                mem_q[wptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/lcd_status_feeder.sv
// Rate-limits processor status updates to the LCD driver: queues sampled
// {estado, opcode} pairs and releases one per HOLD_CYCLES+2 window.
module lcd_status_feeder
    import lcd_feeder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 2500000,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter bit          SUPPRESS_DUP = 1'b1
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic [ESTADO_W-1:0]  iESTADO,
    input  logic [OPCODE_W-1:0]  iOPCODE,
    input  logic                 iVALID,
    output logic [ESTADO_W-1:0]  oESTADO,
    output logic [OPCODE_W-1:0]  oOPCODE,
    output logic                 oFLAG_MUDANCA_LCD,
    output logic                 oOVERFLOW,
    output logic [PENDING_W-1:0] oPENDING
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

    feeder_state_e        state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ESTADO_W-1:0]  estado_q, estado_d;
    logic [OPCODE_W-1:0]  opcode_q, opcode_d;
    logic                 flag_q, flag_d;
    logic                 overflow_q, overflow_d;
    logic [ENTRY_W-1:0]   last_q, last_d;
    logic                 last_valid_q, last_valid_d;

    logic [ENTRY_W-1:0]   entry_s, head_s;
    logic                 full_s, empty_s, pop_s, dup_s, accept_s;
    logic [CW-1:0]        count_s;

    assign entry_s  = pack_entry(iESTADO, iOPCODE);
    assign pop_s    = (state_q == ST_IDLE) && !empty_s;
    assign dup_s    = SUPPRESS_DUP && last_valid_q && (entry_s == last_q);
    assign accept_s = iVALID && !dup_s && (!full_s || pop_s);

    lcd_status_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (iCLK),
        .rst_ni  (iRST_N),
        .push_i  (accept_s),
        .pop_i   (pop_s),
        .wdata_i (entry_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Duplicate filter and sticky overflow; only accepted pushes update the reference.
    always_comb begin
        last_d       = last_q;
        last_valid_d = last_valid_q;
        overflow_d   = overflow_q;
        if (accept_s) begin
            last_d       = entry_s;
            last_valid_d = 1'b1;
        end else begin
            last_d       = last_q;
            last_valid_d = last_valid_q;
        end
        if (iVALID && !dup_s && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Update FSM: pop in IDLE, one-cycle flag in PULSE, then count down the hold window.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        estado_d = estado_q;
        opcode_d = opcode_q;
        flag_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_d  = ST_PULSE;
                    estado_d = head_s[ENTRY_W-1:OPCODE_W];
                    opcode_d = head_s[OPCODE_W-1:0];
                    flag_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                state_d = ST_HOLD;
                timer_d = HOLD_LOAD;
            end
            ST_HOLD: begin
                if (timer_q == {TIMER_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = {TIMER_W{1'b0}};
            end
        endcase
    end

    // State, timer, presented outputs and filter registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= ST_IDLE;
            timer_q      <= {TIMER_W{1'b0}};
            estado_q     <= {ESTADO_W{1'b0}};
            opcode_q     <= {OPCODE_W{1'b0}};
            flag_q       <= 1'b0;
            overflow_q   <= 1'b0;
            last_q       <= {ENTRY_W{1'b0}};
            last_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            estado_q     <= estado_d;
            opcode_q     <= opcode_d;
            flag_q       <= flag_d;
            overflow_q   <= overflow_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign oESTADO           = estado_q;
    assign oOPCODE           = opcode_q;
    assign oFLAG_MUDANCA_LCD = flag_q;
    assign oOVERFLOW         = overflow_q;
    assign oPENDING          = PENDING_W'(count_s);

endmodule

// File: tb/tb_lcd_status_feeder.sv
// Directed bench for lcd_status_feeder with HOLD_CYCLES=8, FIFO_DEPTH=4; a second
// instance with SUPPRESS_DUP=0 shares the stimulus.
module tb_lcd_status_feeder;

    logic        iCLK;
    logic        iRST_N;
    logic [21:0] iESTADO;
    logic [4:0]  iOPCODE;
    logic        iVALID;
    logic [21:0] oESTADO, nd_estado;
    logic [4:0]  oOPCODE, nd_opcode;
    logic        oFLAG, nd_flag;
    logic        oOVF, nd_ovf;
    logic [4:0]  oPEND, nd_pend;

    int n_pass = 0;
    int n_total = 0;

    logic        stim_v [64];
    logic [21:0] stim_e [64];
    logic [4:0]  stim_o [64];
    int          cap_cyc [8];
    logic [21:0] cap_e [8];
    logic [4:0]  cap_o [8];
    logic [4:0]  pend_at [65];
    int          cap_n, nd_n, unstable;
    logic [4:0]  peak;

    lcd_status_feeder #(.HOLD_CYCLES(8), .FIFO_DEPTH(4), .SUPPRESS_DUP(1'b1)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iESTADO(iESTADO), .iOPCODE(iOPCODE), .iVALID(iVALID),
        .oESTADO(oESTADO), .oOPCODE(oOPCODE), .oFLAG_MUDANCA_LCD(oFLAG),
        .oOVERFLOW(oOVF), .oPENDING(oPEND));

    lcd_status_feeder #(.HOLD_CYCLES(8), .FIFO_DEPTH(4), .SUPPRESS_DUP(1'b0)) dut_nd (
        .iCLK(iCLK), .iRST_N(iRST_N), .iESTADO(iESTADO), .iOPCODE(iOPCODE), .iVALID(iVALID),
        .oESTADO(nd_estado), .oOPCODE(nd_opcode), .oFLAG_MUDANCA_LCD(nd_flag),
        .oOVERFLOW(nd_ovf), .oPENDING(nd_pend));

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic clear_stim();
        for (int i = 0; i < 64; i++) begin
            stim_v[i] = 1'b0;
            stim_e[i] = 22'h0;
            stim_o[i] = 5'd0;
        end
    endtask

    task automatic set_push(input int c, input logic [21:0] e, input logic [4:0] o);
        stim_v[c] = 1'b1;
        stim_e[c] = e;
        stim_o[c] = o;
    endtask

    task automatic do_reset();
        iVALID = 1'b0;
        iESTADO = 22'h0;
        iOPCODE = 5'd0;
        iRST_N = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
    endtask

    // Cycle 0 starts just after an edge; cycle c+1 observations follow edge c+1.
    task automatic capture(input int ncyc);
        logic [21:0] prev_e;
        logic [4:0]  prev_o;
        cap_n = 0; nd_n = 0; unstable = 0; peak = 5'd0;
        prev_e = oESTADO; prev_o = oOPCODE;
        for (int c = 0; c < ncyc; c++) begin
            iVALID = stim_v[c]; iESTADO = stim_e[c]; iOPCODE = stim_o[c];
            @(posedge iCLK);
            #1;
            iVALID = 1'b0;
            pend_at[c+1] = oPEND;
            if (oPEND > peak) peak = oPEND;
            if (oFLAG) begin
                if (cap_n < 8) begin
                    cap_cyc[cap_n] = c + 1;
                    cap_e[cap_n] = oESTADO;
                    cap_o[cap_n] = oOPCODE;
                end
                cap_n++;
            end else if (oESTADO !== prev_e || oOPCODE !== prev_o) begin
                unstable++;
            end
            prev_e = oESTADO; prev_o = oOPCODE;
            if (nd_flag) nd_n++;
        end
    endtask

    task automatic test_reset();
        iVALID = 1'b0; iESTADO = 22'h3FFFFF; iOPCODE = 5'h1F;
        iRST_N = 1'b0;
        #3;
        n_total++;
        if ({oESTADO, oOPCODE, oFLAG, oOVF, oPEND} !== 34'h0)
            $display("FAIL reset_outputs: got %0h expected 0", {oESTADO, oOPCODE, oFLAG, oOVF, oPEND});
        else n_pass++;
        do_reset();
        clear_stim();
        capture(5);
        n_total++;
        if (cap_n !== 0 || peak !== 5'd0)
            $display("FAIL reset_idle: got pulses %0d peak %0d expected 0/0", cap_n, peak);
        else n_pass++;
    endtask

    task automatic test_single_push();
        do_reset();
        clear_stim();
        set_push(0, 22'h0ABCDE, 5'd3);
        capture(14);
        n_total++;
        if (pend_at[1] !== 5'd1)
            $display("FAIL single_pending_c1: got %0d expected 1", pend_at[1]);
        else n_pass++;
        n_total++;
        if (cap_n !== 1 || cap_cyc[0] !== 2)
            $display("FAIL single_latency: got %0d pulses first at %0d expected 1 at 2", cap_n, cap_cyc[0]);
        else n_pass++;
        n_total++;
        if (cap_e[0] !== 22'h0ABCDE || cap_o[0] !== 5'd3)
            $display("FAIL single_data: got %0h/%0d expected 0abcde/3", cap_e[0], cap_o[0]);
        else n_pass++;
        n_total++;
        if (pend_at[2] !== 5'd0 || oESTADO !== 22'h0ABCDE || unstable !== 0)
            $display("FAIL single_hold: got pend %0d estado %0h unstable %0d expected 0/0abcde/0",
                     pend_at[2], oESTADO, unstable);
        else n_pass++;
    endtask

    task automatic test_burst();
        do_reset();
        clear_stim();
        set_push(0, 22'h000111, 5'd1);
        set_push(1, 22'h000222, 5'd2);
        set_push(2, 22'h000333, 5'd4);
        capture(30);
        n_total++;
        if (cap_n !== 3 || cap_cyc[0] !== 2 || cap_cyc[1] !== 12 || cap_cyc[2] !== 22)
            $display("FAIL burst_timing: got %0d pulses at %0d,%0d,%0d expected 3 at 2,12,22",
                     cap_n, cap_cyc[0], cap_cyc[1], cap_cyc[2]);
        else n_pass++;
        n_total++;
        if (cap_e[0] !== 22'h000111 || cap_e[1] !== 22'h000222 || cap_e[2] !== 22'h000333 ||
            cap_o[0] !== 5'd1 || cap_o[1] !== 5'd2 || cap_o[2] !== 5'd4)
            $display("FAIL burst_order: got %0h,%0h,%0h expected 111,222,333", cap_e[0], cap_e[1], cap_e[2]);
        else n_pass++;
        n_total++;
        if (unstable !== 0 || oOVF !== 1'b0)
            $display("FAIL burst_stable: got unstable %0d ovf %0b expected 0/0", unstable, oOVF);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        clear_stim();
        for (int i = 0; i < 6; i++) set_push(i, 22'h010000 + 22'(i), 5'(i + 8));
        capture(60);
        n_total++;
        if (peak !== 5'd4)
            $display("FAIL ovf_peak: got %0d expected 4", peak);
        else n_pass++;
        n_total++;
        if (cap_n !== 5 || cap_e[4] !== 22'h010004 || cap_o[4] !== 5'd12)
            $display("FAIL ovf_accepted: got %0d pulses last %0h expected 5 last 010004", cap_n, cap_e[4]);
        else n_pass++;
        n_total++;
        if (oOVF !== 1'b1 || oPEND !== 5'd0)
            $display("FAIL ovf_sticky: got ovf %0b pend %0d expected 1/0", oOVF, oPEND);
        else n_pass++;
    endtask

    task automatic test_duplicates();
        do_reset();
        clear_stim();
        for (int i = 0; i < 3; i++) set_push(i, 22'h2AAAAA, 5'd7);
        capture(30);
        n_total++;
        if (cap_n !== 1 || cap_e[0] !== 22'h2AAAAA)
            $display("FAIL dup_suppressed: got %0d pulses expected 1", cap_n);
        else n_pass++;
        n_total++;
        if (oOVF !== 1'b0 || peak !== 5'd1)
            $display("FAIL dup_side_effects: got ovf %0b peak %0d expected 0/1", oOVF, peak);
        else n_pass++;
        n_total++;
        if (nd_n !== 3)
            $display("FAIL dup_disabled: got %0d pulses expected 3", nd_n);
        else n_pass++;
    endtask

    task automatic test_full_with_pop();
        do_reset();
        clear_stim();
        for (int i = 0; i < 5; i++) set_push(i, 22'h030000 + 22'(i), 5'(i));
        set_push(11, 22'h03FFFF, 5'd31);
        capture(60);
        n_total++;
        if (pend_at[11] !== 5'd4 || pend_at[12] !== 5'd4)
            $display("FAIL full_pop_pending: got %0d,%0d expected 4,4", pend_at[11], pend_at[12]);
        else n_pass++;
        n_total++;
        if (oOVF !== 1'b0)
            $display("FAIL full_pop_ovf: got %0b expected 0", oOVF);
        else n_pass++;
        n_total++;
        if (cap_n !== 6 || cap_cyc[5] !== 52 || cap_e[5] !== 22'h03FFFF || cap_o[5] !== 5'd31)
            $display("FAIL full_pop_drain: got %0d pulses last %0h at %0d expected 6 last 03ffff at 52",
                     cap_n, cap_e[5], cap_cyc[5]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        clear_stim();
        set_push(0, 22'h050001, 5'd1);
        set_push(1, 22'h050002, 5'd2);
        set_push(2, 22'h050003, 5'd3);
        capture(7);
        n_total++;
        if (cap_n !== 1 || oPEND !== 5'd2)
            $display("FAIL midhold_setup: got %0d pulses pend %0d expected 1/2", cap_n, oPEND);
        else n_pass++;
        #2;
        iRST_N = 1'b0;
        #1;
        n_total++;
        if ({oESTADO, oOPCODE, oFLAG, oOVF, oPEND} !== 34'h0)
            $display("FAIL midhold_async: got %0h expected 0", {oESTADO, oOPCODE, oFLAG, oOVF, oPEND});
        else n_pass++;
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
        clear_stim();
        capture(30);
        n_total++;
        if (cap_n !== 0 || peak !== 5'd0)
            $display("FAIL midhold_quiet: got %0d pulses peak %0d expected 0/0", cap_n, peak);
        else n_pass++;
        clear_stim();
        set_push(0, 22'h050003, 5'd3);
        capture(4);
        n_total++;
        if (cap_n !== 1 || cap_cyc[0] !== 2 || cap_e[0] !== 22'h050003)
            $display("FAIL midhold_first_push: got %0d pulses at %0d data %0h expected 1 at 2 data 050003",
                     cap_n, cap_cyc[0], cap_e[0]);
        else n_pass++;
    endtask

    initial begin
        iRST_N = 1'b0;
        iVALID = 1'b0;
        iESTADO = 22'h0;
        iOPCODE = 5'd0;
        test_reset();
        test_single_push();
        test_burst();
        test_overflow();
        test_duplicates();
        test_full_with_pop();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lcd_status_feeder.md
LCD_STATUS_FEEDER -- requirements
Module: lcd_status_feeder

Interface
REQ-001 Parameter HOLD_CYCLES, default 2500000: minimum cycles between update pulses (50 ms at 50 MHz); legal range 1 to 2^24-1.
REQ-002 Parameter FIFO_DEPTH, default 4: pending-update queue depth; power of two, 2 to 16.
REQ-003 Parameter SUPPRESS_DUP, default 1: 1 = drop a push equal to the last accepted entry.
REQ-004 iCLK  input  1  system clock, 50 MHz.
REQ-005 iRST_N  input  1  asynchronous active-low reset.
REQ-006 iESTADO  input  22  processor state word to display.
REQ-007 iOPCODE  input  5  opcode of the committed instruction.
REQ-008 iVALID  input  1  one-cycle strobe; iESTADO/iOPCODE are sampled when it is high.
REQ-009 oESTADO  output  22  state word presented to the LCD display driver.
REQ-010 oOPCODE  output  5  opcode presented to the LCD display driver.
REQ-011 oFLAG_MUDANCA_LCD  output  1  one-cycle pulse: oESTADO/oOPCODE are newly valid.
REQ-012 oOVERFLOW  output  1  sticky: a push was lost because the queue was full.
REQ-013 oPENDING  output  5  current queue occupancy, 0..FIFO_DEPTH.

Function
REQ-014 Each queue entry is {iESTADO, iOPCODE}, 27 bits, stored FIFO order.
REQ-015 Push occurs at the clock edge where iVALID=1, the queue is not full (or a pop happens in the same cycle), and the entry is not suppressed.
REQ-016 The duplicate test compares against a last-accepted register with its own valid bit; the bit is cleared at reset, so the first push is never suppressed.
REQ-017 A push that is attempted while the queue is full with no simultaneous pop is discarded, sets oOVERFLOW, and leaves queue contents unchanged.
REQ-018 A suppressed push neither sets oOVERFLOW nor changes oPENDING.
REQ-019 FSM states: IDLE, PULSE, HOLD.
REQ-020 In IDLE with oPENDING>0, the block pops the head at the next edge, loads oESTADO/oOPCODE from it, sets oFLAG_MUDANCA_LCD=1, and enters PULSE.
REQ-021 In IDLE with oPENDING=0, the block stays in IDLE; outputs hold and the flag stays 0.
REQ-022 PULSE lasts exactly one cycle (flag high); it then enters HOLD with timer loaded to HOLD_CYCLES-1 and clears the flag.
REQ-023 HOLD decrements the timer each cycle; at timer=0 it goes to IDLE; no pop occurs in PULSE or HOLD.
REQ-024 Latency: iVALID at cycle 0 into an empty queue in IDLE produces the updated outputs and flag in cycle 2.
REQ-025 Consecutive flag pulses are spaced at least HOLD_CYCLES+2 cycles apart.
REQ-026 A simultaneous push and pop leaves oPENDING unchanged and is legal even when the queue is full.
REQ-027 Read/write pointers wrap modulo FIFO_DEPTH; occupancy is tracked by a separate counter.
REQ-028 oESTADO/oOPCODE change only on the pop edge; they are otherwise stable.

Reset
REQ-029 Asserting iRST_N low, at any time including mid-HOLD, asynchronously forces: state IDLE; timer 0; queue empty; pointers 0; last-valid 0; oESTADO=0; oOPCODE=0; oFLAG_MUDANCA_LCD=0; oOVERFLOW=0; oPENDING=0.
REQ-030 Only reset clears oOVERFLOW.
REQ-031 Reset deassertion is synchronised upstream (by the reset-delay block); the block does not add its own synchroniser.

Structure
REQ-032 Shared package lcd_feeder_pkg holds the FSM state enum (IDLE/PULSE/HOLD), ESTADO_W=22, OPCODE_W=5, and the entry width ENTRY_W=27.
REQ-033 The queue is a sub-module lcd_status_fifo (parameterised width and depth, with push/pop/full/empty/count); the FSM, timer and duplicate filter live in the top.
REQ-034 No combinational path exists from any input to any output.

Verification (HOLD_CYCLES=8, FIFO_DEPTH=4)
REQ-035 Single push: iVALID at cycle 0 with iESTADO=22'h0ABCDE, iOPCODE=5'd3 -> cycle 2: oESTADO=22'h0ABCDE, oOPCODE=3, flag=1 for one cycle; oPENDING returns to 0.
REQ-036 Burst: 3 distinct pushes on consecutive cycles -> 3 flag pulses at cycles 2, 12, 22, in push order.
REQ-037 Overflow: 6 distinct pushes on back-to-back cycles starting in IDLE -> 5 accepted (one popped at cycle 2, 4 queued), 1 lost; oOVERFLOW=1 and stays 1; oPENDING peaks at 4.
REQ-038 Duplicates: the same {estado, opcode} pushed 3 times -> exactly 1 flag pulse; oOVERFLOW stays 0; with SUPPRESS_DUP=0 -> 3 pulses.
REQ-039 Reset mid-HOLD: assert iRST_N=0 at cycle 5 of HOLD with 2 entries pending -> all outputs 0 immediately; after release, no flag appears until a new push.
REQ-040 Full plus simultaneous pop: queue full, push on the cycle IDLE pops -> push accepted, oPENDING stays 4, no overflow.
